// File: rtl/axi_ddc_plan_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi_ddc_plan_regs
// Brief    : AXI4-Lite register block that streams the per-channel k plan
//            into the DDC plan RAM, issues commit pulses and exposes MODE/STATUS.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ddc_plan_regs #(
    parameter int N_CH       = 128,
    parameter int K_WIDTH    = 14,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic                     plan_we,
    output logic [$clog2(N_CH)-1:0]  plan_addr,
    output logic [K_WIDTH-1:0]       plan_data,
    output logic                     plan_commit,
    output logic [31:0]              mode
);

    localparam int         C_PA_W      = $clog2(N_CH);
    localparam int         C_CNT_W     = 8;
    localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(N_CH);
    localparam logic [2:0] C_REG_PLAN   = 3'd0;
    localparam logic [2:0] C_REG_CTRL   = 3'd1;
    localparam logic [2:0] C_REG_RSVD   = 3'd2;
    localparam logic [2:0] C_REG_STATUS = 3'd3;
    localparam logic [2:0] C_REG_MODE   = 3'd4;
    localparam logic [1:0] C_OKAY       = 2'b00;
    localparam logic [1:0] C_SLVERR     = 2'b10;

    // Write-channel holders
    logic                 r_aw_held;
    logic [2:0]           r_wsel;
    logic                 r_w_held;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;

    // Read channel
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;

    // Plan / control state
    logic                 r_plan_we;
    logic [C_PA_W-1:0]    r_plan_addr;
    logic [K_WIDTH-1:0]   r_plan_data;
    logic                 r_plan_commit;
    logic [31:0]          r_mode;
    logic [C_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_committed;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_b_hs;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_exec;
    logic                 w_wr_err;
    logic                 w_count_full;
    logic [2:0]           w_rsel;
    logic [31:0]          w_rd_data;
    logic [1:0]           w_rd_resp;
    logic                 w_unused;

    // Byte offset bits carry no meaning in this register map.
    assign w_unused = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = !reset && !r_aw_held && !r_bvalid;
    assign s_axi_wready  = !reset && !r_w_held  && !r_bvalid;
    assign s_axi_arready = !reset && !r_rvalid;

    assign w_aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_w_hs       = s_axi_wvalid  && s_axi_wready;
    assign w_b_hs       = r_bvalid && s_axi_bready;
    assign w_ar_hs      = s_axi_arvalid && s_axi_arready;
    assign w_r_hs       = r_rvalid && s_axi_rready;
    // Holders stay set while bvalid is up, so !r_bvalid makes the write fire once.
    assign w_exec       = r_aw_held && r_w_held && !r_bvalid;
    assign w_wr_err     = (r_wsel > C_REG_MODE);
    assign w_count_full = (r_count >= C_CNT_FULL);
    assign w_rsel       = s_axi_araddr[4:2];

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_wsel    <= 3'd0;
            r_w_held  <= 1'b0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_bvalid  <= 1'b0;
            r_bresp   <= C_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_wsel    <= s_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_exec) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? C_SLVERR : C_OKAY;
            end else if (w_b_hs) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_plan_we     <= 1'b0;
            r_plan_addr   <= '0;
            r_plan_data   <= '0;
            r_plan_commit <= 1'b0;
            r_mode        <= 32'd0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_committed   <= 1'b0;
        end else begin
            r_plan_we     <= 1'b0;
            r_plan_commit <= 1'b0;
            if (w_exec) begin
                case (r_wsel)
                    C_REG_PLAN: begin
                        r_committed <= 1'b0;
                        if (!w_count_full) begin
                            r_plan_we   <= 1'b1;
                            r_plan_addr <= r_count[C_PA_W-1:0];
                            r_plan_data <= r_wdata[K_WIDTH-1:0];
                            r_count     <= r_count + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    C_REG_CTRL: begin
                        if (r_wdata[0]) begin
                            r_plan_commit <= 1'b1;
                            r_committed   <= 1'b1;
                            r_count       <= '0;
                            r_overflow    <= 1'b0;
                        end else if (r_wdata[1]) begin
                            r_committed   <= 1'b0;
                            r_count       <= '0;
                            r_overflow    <= 1'b0;
                        end
                    end
                    C_REG_MODE: begin
                        for (int b = 0; b < 4; b++) begin
                            if (r_wstrb[b]) begin
                                r_mode[8*b +: 8] <= r_wdata[8*b +: 8];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux sees the registers before any write retiring this cycle.
    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = C_OKAY;
        case (w_rsel)
            C_REG_PLAN:   w_rd_data = {24'd0, r_count};
            C_REG_CTRL:   w_rd_data = 32'd0;
            C_REG_RSVD:   w_rd_data = 32'd0;
            C_REG_STATUS: w_rd_data = {r_committed, r_overflow, 22'd0, r_count};
            C_REG_MODE:   w_rd_data = r_mode;
            default:      w_rd_resp = C_SLVERR;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= C_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign plan_we      = r_plan_we;
    assign plan_addr    = r_plan_addr;
    assign plan_data    = r_plan_data;
    assign plan_commit  = r_plan_commit;
    assign mode         = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_axi_ddc_plan_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ddc_plan_regs
// Brief    : Randomized self-checking bench for axi_ddc_plan_regs with a
//            register-map reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ddc_plan_regs;

    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        plan_we;
    logic [6:0]  plan_addr;
    logic [13:0] plan_data;
    logic        plan_commit;
    logic [31:0] mode;

    always #5 clk_100MHz = ~clk_100MHz;

    axi_ddc_plan_regs #(.N_CH(128), .K_WIDTH(14), .ADDR_WIDTH(5)) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .plan_we       (plan_we),
        .plan_addr     (plan_addr),
        .plan_data     (plan_data),
        .plan_commit   (plan_commit),
        .mode          (mode)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the architectural register state
    int          m_count   = 0;
    bit          m_ovf     = 1'b0;
    bit          m_comm    = 1'b0;
    logic [31:0] m_mode    = '0;
    int          m_commits = 0;
    int          obs_commits = 0;
    logic [20:0] exp_q[$];

    task automatic model_write(input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        resp = 2'b00;
        case (a[4:2])
            3'd0: begin
                m_comm = 1'b0;
                if (m_count < 128) begin
                    exp_q.push_back({7'(m_count), d[13:0]});
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            3'd1: begin
                if (d[0]) begin
                    m_commits++;
                    m_comm = 1'b1; m_count = 0; m_ovf = 1'b0;
                end else if (d[1]) begin
                    m_comm = 1'b0; m_count = 0; m_ovf = 1'b0;
                end
            end
            3'd4: for (int b = 0; b < 4; b++) if (s[b]) m_mode[8*b +: 8] = d[8*b +: 8];
            3'd2, 3'd3: ;
            default: resp = 2'b10;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, output logic [1:0] resp);
        resp = 2'b00;
        case (a[4:2])
            3'd0:       return 32'(m_count);
            3'd1, 3'd2: return 32'd0;
            3'd3:       return {m_comm, m_ovf, 22'd0, 8'(m_count)};
            3'd4:       return m_mode;
            default: begin resp = 2'b10; return 32'd0; end
        endcase
    endfunction

    // Plan strobes and commits must coincide with bvalid rising
    logic        prev_bvalid = 1'b0;
    logic [20:0] exp_ent;
    always @(negedge clk_100MHz) begin
        if (plan_we) begin
            check_val("we_at_brise", 32'(bvalid && !prev_bvalid), 32'd1);
            check_val("we_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_ent = exp_q.pop_front();
                check_val("plan_addr", 32'(plan_addr), 32'(exp_ent[20:14]));
                check_val("plan_data", 32'(plan_data), 32'(exp_ent[13:0]));
            end
        end
        if (plan_commit) begin
            obs_commits++;
            check_val("commit_at_brise", 32'(bvalid && !prev_bvalid), 32'd1);
        end
        prev_bvalid = bvalid;
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_start, input int w_start, input int b_delay);
        logic [1:0] exp_resp;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n;
        model_write(a, d, s, exp_resp);
        awaddr = a; wdata = d; wstrb = s;
        for (int t = 0; t < 64 && !(aw_done && w_done); t++) begin
            if (t == aw_start && !aw_done) awvalid = 1'b1;
            if (t == w_start && !w_done)   wvalid  = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk_100MHz);
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("wr_handshake", 32'(aw_done && w_done), 32'd1);
        n = 0;
        while (n < 16 && !bvalid) begin
            @(negedge clk_100MHz);
            n++;
        end
        check_val("b_latency", 32'(n), 32'd1);
        for (int i = 0; i < b_delay; i++) begin
            check_val("b_hold", {29'd0, bvalid, awready, wready}, 32'd4);
            @(negedge clk_100MHz);
        end
        check_val("bresp", 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        @(negedge clk_100MHz);
        bready = 1'b0;
        check_val("bvalid_clr", 32'(bvalid), 32'd0);
        check_val("mode_out", mode, m_mode);
    endtask

    task automatic axi_read(input logic [4:0] a, input int r_delay, output logic [31:0] got);
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        bit done = 0, hs;
        exp_data = model_read(a, exp_resp);
        araddr = a; arvalid = 1'b1;
        for (int t = 0; t < 16 && !done; t++) begin
            hs = arready;
            @(negedge clk_100MHz);
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        arvalid = 1'b0;
        check_val("ar_handshake", 32'(done), 32'd1);
        check_val("rvalid_latency", 32'(rvalid), 32'd1);
        for (int i = 0; i < r_delay; i++) begin
            @(negedge clk_100MHz);
            check_val("r_hold", {31'd0, rvalid}, 32'd1);
        end
        got = rdata;
        check_val($sformatf("rdata@%02h", a), rdata, exp_data);
        check_val($sformatf("rresp@%02h", a), 32'(rresp), 32'(exp_resp));
        rready = 1'b1;
        @(negedge clk_100MHz);
        rready = 1'b0;
        check_val("rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int op;

        repeat (3) @(negedge clk_100MHz);
        check_val("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check_val("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check_val("rst_plan", {9'd0, plan_we, plan_commit, plan_addr, plan_data}, 32'd0);
        check_val("rst_mode", mode, 32'd0);
        check_val("rst_resp", {rdata[29:0], bresp}, 32'd0);
        reset = 1'b0;
        @(negedge clk_100MHz);
        axi_read(5'h0C, 0, rd);

        // Full plan load and commit
        for (int i = 0; i < 128; i++) axi_write(5'h00, 32'(i), 4'hF, 0, 0, 0);
        axi_write(5'h04, 32'd1, 4'hF, 0, 0, 0);
        check_val("commits_full", 32'(obs_commits), 32'd1);
        axi_read(5'h0C, 0, rd);
        check_val("status_committed", rd, 32'h8000_0000);

        // Overflow then clear
        for (int i = 0; i < 129; i++) axi_write(5'h00, $urandom, 4'hF, 0, 0, 0);
        axi_read(5'h0C, 1, rd);
        check_val("status_ovf", rd, 32'h4000_0080);
        axi_write(5'h04, 32'd2, 4'hF, 1, 0, 0);
        axi_read(5'h0C, 0, rd);
        check_val("status_clr", rd, 32'h0000_0000);
        check_val("commits_clr", 32'(obs_commits), 32'd1);

        // MODE byte strobes
        axi_write(5'h10, 32'hAABB_CCDD, 4'b1111, 0, 0, 0);
        axi_write(5'h10, 32'h1122_3344, 4'b0101, 0, 0, 0);
        axi_read(5'h10, 0, rd);
        check_val("mode_strb", rd, 32'hAA22_CC44);
        check_val("mode_pin", mode, 32'hAA22_CC44);

        // W three cycles ahead of AW, B held off five cycles
        axi_write(5'h00, 32'h0000_1234, 4'hF, 3, 0, 5);

        // Unmapped addresses
        axi_read(5'h18, 0, rd);
        axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        check_val("mode_after_err", mode, 32'hAA22_CC44);

        // Reset in the middle of a PLAN stream drops the in-flight write
        axi_write(5'h04, 32'd2, 4'hF, 0, 0, 0);
        for (int i = 0; i < 5; i++) axi_write(5'h00, 32'(100 + i), 4'hF, 0, 0, 0);
        awaddr = 5'h00; wdata = 32'd105; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk_100MHz);
        awvalid = 1'b0; wvalid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        m_count = 0; m_ovf = 1'b0; m_comm = 1'b0; m_mode = '0;
        for (int i = 0; i < 3; i++) begin
            check_val("no_b_after_rst", 32'(bvalid), 32'd0);
            @(negedge clk_100MHz);
        end
        axi_read(5'h0C, 0, rd);
        check_val("status_after_rst", rd, 32'd0);
        for (int i = 0; i < 4; i++) axi_write(5'h00, 32'(106 + i), 4'hF, 0, 0, 0);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: axi_write({3'd0, 2'($urandom)}, $urandom, 4'($urandom),
                                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                4: axi_write({3'd1, 2'($urandom)}, 32'($urandom_range(0, 3)), 4'hF,
                             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                5: axi_write({3'd4, 2'($urandom)}, $urandom, 4'($urandom),
                             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                6: axi_write({3'($urandom_range(2, 7)), 2'($urandom)}, $urandom, 4'($urandom),
                             0, $urandom_range(0, 2), 0);
                default: axi_read(5'($urandom), $urandom_range(0, 2), rd);
            endcase
        end

        repeat (2) @(negedge clk_100MHz);
        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_val("commit_count", 32'(obs_commits), 32'(m_commits));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
